// File: rtl/sort_mon_pkg.sv
// Shared definitions for the sort result monitor.
//   NUM_ELEM        : number of array taps observed
//   DEF_DATA_W/CNT_W: default tap and counter widths
//   mon_state_e     : monitor FSM states
//   sat_inc()       : increment that sticks at a caller-supplied maximum
package sort_mon_pkg;

  localparam int NUM_ELEM   = 8;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } mon_state_e;

  // Width-agnostic saturating increment; callers zero-extend to 64 bits
  // and pass their own all-ones value as the ceiling.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sort_order_check.sv
// Combinational ascending-order check over NUM_ELEM signed taps.
//   elem_i   : packed taps, index 0 = lowest address
//   sorted_o : 1 when every neighbour pair is non-decreasing (signed)
module sort_order_check
  import sort_mon_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [NUM_ELEM-1:0][DATA_W-1:0] elem_i,
  output logic                            sorted_o
);

  logic [NUM_ELEM-2:0] pair_ok;

  for (genvar i = 0; i < NUM_ELEM - 1; i++) begin : g_pair
    assign pair_ok[i] = $signed(elem_i[i]) <= $signed(elem_i[i+1]);
  end

  assign sorted_o = &pair_ok;

endmodule

// File: rtl/sort_result_monitor.sv
// Passive completion monitor for the selection-sort processor.
// Counts total/stall/flush cycles, detects when the observed array is sorted
// and has held unchanged for STABLE_CYCLES edges, then freezes and reports.
//   clk, reset           : clock, async active-high reset
//   element1..element8   : array taps (element1 = lowest address)
//   stall, flush         : pipeline status
//   done                 : finished (sorted completion or timeout)
//   sorted_ok            : finished with a sorted array
//   cycle/stall/flush_count : saturating counters, frozen when done
//   done_cycle           : cycle_count at the first edge of the final stable window
//   sat                  : sticky, some counter hit all-ones
module sort_result_monitor
  import sort_mon_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_CYCLES    = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] element1,
  input  logic [DATA_W-1:0] element2,
  input  logic [DATA_W-1:0] element3,
  input  logic [DATA_W-1:0] element4,
  input  logic [DATA_W-1:0] element5,
  input  logic [DATA_W-1:0] element6,
  input  logic [DATA_W-1:0] element7,
  input  logic [DATA_W-1:0] element8,
  input  logic              stall,
  input  logic              flush,
  output logic              done,
  output logic              sorted_ok,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  done_cycle,
  output logic              sat
);

  localparam logic [CNT_W-1:0] CNT_ONES   = '1;
  localparam logic [7:0]       STABLE_TGT = 8'(STABLE_CYCLES);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), 64'(CNT_ONES)));
  endfunction

  logic [NUM_ELEM-1:0][DATA_W-1:0] elem;
  assign elem = {element8, element7, element6, element5,
                 element4, element3, element2, element1};

  logic sorted;
  sort_order_check #(.DATA_W(DATA_W)) u_order (
    .elem_i   (elem),
    .sorted_o (sorted)
  );

  mon_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                cycle_q, cycle_d;
  logic [CNT_W-1:0]                stall_q, stall_d;
  logic [CNT_W-1:0]                flush_q, flush_d;
  logic [CNT_W-1:0]                dc_q, dc_d;
  logic [7:0]                      stable_q, stable_d;
  logic [NUM_ELEM-1:0][DATA_W-1:0] prev_q, prev_d;
  logic                            prev_vld_q, prev_vld_d;
  logic                            sat_q, sat_d;
  logic                            ok_q, ok_d;

  logic changed, hit_max;
  assign changed = !prev_vld_q || (elem != prev_q);
  // Compare in 64 bits so a saturated narrow counter can never alias MAX_CYCLES.
  assign hit_max = (64'(cycle_q) + 64'd1) == 64'(MAX_CYCLES);

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    dc_d       = dc_q;
    stable_d   = stable_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    sat_d      = sat_q;
    ok_d       = ok_q;
    if (state_q == ST_RUN) begin
      cycle_d    = inc(cycle_q);
      stall_d    = stall ? inc(stall_q) : stall_q;
      flush_d    = flush ? inc(flush_q) : flush_q;
      prev_d     = elem;
      prev_vld_d = 1'b1;
      if (sorted && !changed) begin
        stable_d = stable_q + 8'd1;
        // First edge of a stable window: remember when the values appeared.
        if (stable_q == 8'd0) dc_d = cycle_q;
      end else begin
        stable_d = 8'd0;
      end
      sat_d = sat_q || (cycle_d == CNT_ONES) || (stall_d == CNT_ONES) ||
              (flush_d == CNT_ONES);
      if (stable_d == STABLE_TGT) begin
        state_d = ST_DONE;
        ok_d    = 1'b1;
      end else if (hit_max) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cycle_q    <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
      dc_q       <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      sat_q      <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      dc_q       <= dc_d;
      stable_q   <= stable_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      sat_q      <= sat_d;
      ok_q       <= ok_d;
    end
  end

  assign done        = (state_q != ST_RUN);
  assign sorted_ok   = ok_q;
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;
  assign done_cycle  = dc_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_sort_result_monitor.sv
module tb_sort_result_monitor;
  localparam int DW   = 64;
  localparam int S    = 16;
  localparam int MAXC = 150;

  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic signed [DW-1:0] e [8];

  logic        done1, ok1, sat1;
  logic [31:0] cyc1, st1, fl1, dc1;
  logic        done2, ok2, sat2;
  logic [3:0]  cyc2, st2, fl2, dc2;

  int total = 0, bad = 0;

  typedef struct { int cyc; int st; int fl; int dc; bit ok; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sort_result_monitor #(.DATA_W(DW), .CNT_W(32), .STABLE_CYCLES(S), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset),
    .element1(e[0]), .element2(e[1]), .element3(e[2]), .element4(e[3]),
    .element5(e[4]), .element6(e[5]), .element7(e[6]), .element8(e[7]),
    .stall(stall), .flush(flush),
    .done(done1), .sorted_ok(ok1), .cycle_count(cyc1), .stall_count(st1),
    .flush_count(fl1), .done_cycle(dc1), .sat(sat1));

  // Narrow-counter instance for saturation behaviour.
  sort_result_monitor #(.DATA_W(DW), .CNT_W(4), .STABLE_CYCLES(S), .MAX_CYCLES(100000)) dut_n (
    .clk(clk), .reset(reset),
    .element1(e[0]), .element2(e[1]), .element3(e[2]), .element4(e[3]),
    .element5(e[4]), .element6(e[5]), .element7(e[6]), .element8(e[7]),
    .stall(stall), .flush(flush),
    .done(done2), .sorted_ok(ok2), .cycle_count(cyc2), .stall_count(st2),
    .flush_count(fl2), .done_cycle(dc2), .sat(sat2));

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_n, m_st, m_fl, m_run, m_dc, m_fin;
  bit  m_pv;
  logic signed [DW-1:0] m_prev [8];

  function automatic bit ref_sorted();
    for (int i = 0; i < 7; i++)
      if (e[i] > e[i+1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_n = 0; m_st = 0; m_fl = 0; m_run = 0; m_dc = 0; m_fin = 0; m_pv = 1'b0;
    for (int i = 0; i < 8; i++) m_prev[i] = '0;
  endtask

  // Predicts the effect of the next rising edge on the current inputs.
  task automatic model_edge();
    bit   same;
    exp_t x;
    if (m_fin != 0) return;
    m_n++;
    m_st += int'(stall);
    m_fl += int'(flush);
    same = m_pv;
    for (int i = 0; i < 8; i++) if (e[i] !== m_prev[i]) same = 1'b0;
    if (ref_sorted() && same) begin
      if (m_run == 0) m_dc = m_n - 1;
      m_run++;
    end else begin
      m_run = 0;
    end
    for (int i = 0; i < 8; i++) m_prev[i] = e[i];
    m_pv = 1'b1;
    if (m_run == S || m_n == MAXC) begin
      m_fin = (m_run == S) ? 1 : 2;
      x.cyc = m_n; x.st = m_st; x.fl = m_fl; x.dc = m_dc; x.ok = (m_run == S);
      exp_q.push_back(x);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  bit   have = 1'b0, done_prev = 1'b0;

  always @(negedge clk) begin
    if (done1 && !done_prev) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at cycle_count=%0d", cyc1);
        have = 1'b0;
      end else begin
        cur  = exp_q.pop_front();
        have = 1'b1;
      end
    end
    if (done1 && have) begin
      chk("mon_cycle_count", cyc1, cur.cyc);
      chk("mon_stall_count", st1, cur.st);
      chk("mon_flush_count", fl1, cur.fl);
      chk("mon_done_cycle", dc1, cur.dc);
      chk("mon_sorted_ok", ok1, cur.ok);
      chk("mon_sat", sat1, 0);
    end
    if (!done1) have = 1'b0;
    done_prev = done1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("pending_done", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b1;
    #1;
    chk("rst_done", done1, 0);
    chk("rst_sorted_ok", ok1, 0);
    chk("rst_cycle_count", cyc1, 0);
    chk("rst_stall_count", st1, 0);
    chk("rst_flush_count", fl1, 0);
    chk("rst_done_cycle", dc1, 0);
    chk("rst_sat", sat1, 0);
    chk("rst_n_cycle_count", cyc2, 0);
    chk("rst_n_sat", sat2, 0);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_vec(input longint a0, a1, a2, a3, a4, a5, a6, a7);
    e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
    e[4] = a4; e[5] = a5; e[6] = a6; e[7] = a7;
  endtask

  task automatic rand_ctl();
    stall = ($urandom % 4) == 0;
    flush = ($urandom % 6) == 0;
  endtask

  task automatic rand_vec();
    longint v [8];
    longint t;
    for (int i = 0; i < 8; i++)
      v[i] = (($urandom % 4) == 0) ? longint'({$urandom, $urandom})
                                   : longint'($urandom_range(0, 20)) - 10;
    if ($urandom % 2) begin
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 7 - i; j++)
          if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    end
    for (int i = 0; i < 8; i++) e[i] = v[i];
  endtask

  initial begin
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;

    // A: unsorted forever -> timeout at MAXC, frozen afterwards
    do_reset();
    set_vec(5, 3, 8, 1, 9, 2, 7, 4);
    for (int t = 0; t < 200; t++) begin rand_ctl(); tick(); end
    chk("A_done", done1, 1);
    chk("A_sorted_ok", ok1, 0);
    chk("A_cycle_count", cyc1, 150);

    // B: becomes sorted on the 40th edge; stall 7 / flush 3 with one overlap
    do_reset();
    for (int t = 1; t <= 120; t++) begin
      if (t < 40) set_vec(5, 3, 8, 1, 9, 2, 7, 4);
      else        set_vec(1, 2, 3, 4, 5, 7, 8, 9);
      stall = (t >= 5 && t <= 11);
      flush = (t >= 11 && t <= 13);
      tick();
    end
    chk("B_done_cycle", dc1, 40);
    chk("B_cycle_count", cyc1, 56);
    chk("B_sorted_ok", ok1, 1);
    chk("B_stall_count", st1, 7);
    chk("B_flush_count", fl1, 3);

    // C: element3 glitches for one edge inside a stable window
    do_reset();
    for (int t = 1; t <= 90; t++) begin
      if (t < 20) set_vec(9, 8, 7, 6, 5, 4, 3, 2);
      else        set_vec(1, 2, (t == 30) ? 100 : 3, 4, 5, 6, 7, 8);
      rand_ctl();
      tick();
    end
    chk("C_done_cycle", dc1, 31);
    chk("C_cycle_count", cyc1, 47);

    // D: negative values, already sorted from the start
    do_reset();
    set_vec(-5, -5, -1, 0, 0, 2, 3, 100);
    for (int t = 0; t < 40; t++) begin rand_ctl(); tick(); end
    chk("D_sorted_ok", ok1, 1);
    chk("D_cycle_count", cyc1, 17);
    chk("D_done_cycle", dc1, 1);

    // E: all-ones in element8 is -1 -> unsorted
    do_reset();
    set_vec(1, 2, 3, 4, 5, 6, 7, -1);
    for (int t = 0; t < 160; t++) begin rand_ctl(); tick(); end
    chk("E_sorted_ok", ok1, 0);
    chk("E_cycle_count", cyc1, 150);

    // F: asynchronous reset mid-run
    do_reset();
    set_vec(5, 3, 8, 1, 9, 2, 7, 4);
    for (int t = 0; t < 25; t++) begin rand_ctl(); tick(); end
    chk("F_pre_cycle_count", cyc1, 25);
    do_reset();
    tick();
    chk("F_post_cycle_count", cyc1, 1);
    for (int t = 0; t < 10; t++) begin rand_ctl(); tick(); end

    // G: narrow counters saturate and set sat
    do_reset();
    set_vec(5, 3, 8, 1, 9, 2, 7, 4);
    stall = 1'b1;
    flush = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    chk("G_n_cycle_10", cyc2, 10);
    chk("G_n_sat_early", sat2, 0);
    for (int t = 0; t < 20; t++) tick();
    chk("G_n_cycle_sat", cyc2, 15);
    chk("G_n_stall_sat", st2, 15);
    chk("G_n_flush_sat", fl2, 15);
    chk("G_n_sat", sat2, 1);
    chk("G_wide_sat", sat1, 0);

    // H: randomised hold patterns
    for (int p = 0; p < 6; p++) begin
      int t;
      do_reset();
      t = 0;
      while (t < 160) begin
        int len;
        rand_vec();
        len = $urandom_range(1, 25);
        for (int k = 0; k < len; k++) begin rand_ctl(); tick(); t++; end
      end
    end
    tick();
    tick();
    chk("final_pending_done", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_result_monitor.md
Name: sort_result_monitor

Overview:
- Passive observer for the pipelined selection-sort processor. It consumes the element1..element8 result taps and the stall/flush status from RISC_V_Processor.
- Counts total, stall and flush cycles.
- Decides when the array has been sorted and has stayed unchanged long enough to count as final. It then latches the completion cycle and raises done with a pass/fail flag.
- Sits beside the processor in the top-level bench/FPGA wrapper. It replaces ad-hoc clock_cycle counting with a synthesizable, checkable block.

Parameters:
- DATA_W, 64, width of each element tap.
- CNT_W, 32, width of every counter output.
- STABLE_CYCLES, 64, number of consecutive sorted-and-unchanged cycles required to declare completion (range 1..255).
- MAX_CYCLES, 100000, cycle_count value at which the monitor gives up (TIMEOUT).

Ports:
- clk  input  1  processor clock
- reset  input  1  asynchronous, active-high reset
- element1..element8  input  DATA_W each  array taps, element1 = lowest address
- stall  input  1  pipeline stall indicator
- flush  input  1  pipeline flush indicator
- done  output  1  monitor finished (DONE or TIMEOUT)
- sorted_ok  output  1  1 = finished with array sorted; 0 = timeout or still running
- cycle_count  output  CNT_W  cycles since reset release, frozen at finish
- stall_count  output  CNT_W  cycles with stall=1
- flush_count  output  CNT_W  cycles with flush=1
- done_cycle  output  CNT_W  cycle_count value at the first cycle of the final stable window
- sat  output  1  sticky: some counter saturated

Behaviour:
- Reset (async, active-high):
  - state=RUN.
  - All counters, done_cycle, stable_cnt and prev_elem[1..8] cleared to 0.
  - prev_valid=0; done=0, sorted_ok=0, sat=0.
- Sorted predicate (combinational): signed compare, element(i) <= element(i+1) for i=1..7. Equal neighbours count as sorted.
- Changed predicate: any element differs from prev_elem, or prev_valid=0.
- RUN state, every rising edge:
  - cycle_count += 1.
  - stall_count += stall.
  - flush_count += flush.
  - prev_elem <= elements; prev_valid <= 1.
  - Counters saturate at all-ones; when any counter saturates, sat is set and held.
  - If sorted && !changed: stable_cnt += 1. On the transition 0->1, done_cycle <= cycle_count (pre-increment value), i.e. the cycle the final values first appeared.
  - Otherwise stable_cnt <= 0.
  - If stable_cnt reaches STABLE_CYCLES on this edge: go to DONE; done=1, sorted_ok=1 become visible the next cycle.
  - Else if cycle_count+1 == MAX_CYCLES: go to TIMEOUT; done=1, sorted_ok=0.
  - Both on the same edge: DONE wins.
- stall and flush asserted simultaneously: both counters increment.
- DONE / TIMEOUT: all counters and outputs frozen and input activity is ignored. Only reset leaves these states.
- Reset mid-run: immediate async return to the reset values. Counting restarts from 1 on the first edge after release.
- Already-sorted initial array: completes after 1 + STABLE_CYCLES edges. This is legitimate and not an error.
- Latency: done rises STABLE_CYCLES+1 edges after the last element change.

Decomposition:
- Package sort_mon_pkg holds:
  - state enum {RUN, DONE, TIMEOUT}
  - NUM_ELEM=8
  - default DATA_W/CNT_W
  - a saturating-increment function
- Sub-module sort_order_check: combinational, takes the 8 elements and outputs the sorted bit. Reusable by the bench scoreboard.
- Remaining logic (counters, FSM, change detect) stays in sort_result_monitor; expected size is about 200 lines.

Test Plan:
- Elements fixed at 5,3,8,1,9,2,7,4 for 200 cycles, with STABLE_CYCLES=16 and MAX_CYCLES=150 -> done=1 and sorted_ok=0 at cycle_count=150, counters frozen thereafter.
- Elements start at 5,3,8,1,9,2,7,4, then change to 1,2,3,4,5,7,8,9 at cycle 40 and stay (STABLE_CYCLES=16) -> done_cycle=40, done rises when cycle_count=56, sorted_ok=1.
- Sorted values held but element3 toggles for one cycle at cycle 30, then restores -> stable_cnt restarts and done_cycle equals the cycle after the restore.
- stall pulsed for 7 cycles and flush for 3, with one overlapping cycle -> stall_count=7, flush_count=3, cycle_count unaffected.
- Negative values -5,-5,-1,0,0,2,3,100 held -> sorted via signed compare, sorted_ok=1. Also drive 0xFFFF_FFFF_FFFF_FFFF (-1) in element8 against positives -> treated as unsorted.
- Reset asserted mid-run at cycle 25 for 3 ns -> all outputs return to 0 asynchronously, and cycle_count=1 on the first edge after release. Separately, with CNT_W=4 and a long run -> counters stick at 15 and sat=1.
